// File: rtl/alu_exec_ctrl.sv
// Execution controller around a 4-op ALU: register file, valid/ready instruction intake,
// registered operand drive and writeback of result plus Z/N/V flags. Optional: ALU_SAT_EN.
module alu_exec_ctrl #(
    parameter int DATA_W = 4,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs,
    input  logic [AW-1:0]     instr_rt,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [1:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_error,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                        state_q, state_d;
    logic [NREG-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic [DATA_W-1:0]             alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0]             alu_in2_q, alu_in2_d;
    logic [1:0]                    alu_opcode_q, alu_opcode_d;
    logic [AW-1:0]                 rd_q, rd_d;
    logic [DATA_W-1:0]             result_q, result_d;
    logic                          done_q, done_d;
    logic                          flag_z_q, flag_z_d;
    logic                          flag_n_q, flag_n_d;
    logic                          flag_v_q, flag_v_d;
    logic                          accept;
    logic                          arith;
    logic [DATA_W-1:0]             wb;

    assign instr_ready = (state_q != EXEC);
    assign accept      = instr_valid & instr_ready;
    assign arith       = ~alu_opcode_q[1];

    always_comb begin
        wb = alu_out;
`ifdef ALU_SAT_EN
        // Clamp toward the sign of operand A on signed overflow of ADD/SUB.
        if (arith && alu_error)
            wb = alu_in1_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    end

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_opcode_d = alu_opcode_q;
        rd_d         = rd_q;
        result_d     = result_q;
        done_d       = 1'b0;
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
        flag_v_d     = flag_v_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    alu_in1_d    = (instr_rs == '0) ? '0 : regs_q[instr_rs];
                    alu_in2_d    = (instr_rt == '0) ? '0 : regs_q[instr_rt];
                    alu_opcode_d = instr_op;
                    rd_d         = instr_rd;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (rd_q != '0)
                    regs_d[rd_q] = wb;
                result_d = wb;
                flag_z_d = (wb == '0);
                flag_n_d = wb[DATA_W-1];
                flag_v_d = arith & alu_error;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            regs_q       <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_opcode_q <= '0;
            rd_q         <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_opcode_q <= alu_opcode_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            done_q       <= done_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
            flag_v_q     <= flag_v_d;
        end
    end

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_opcode = alu_opcode_q;
    assign result     = result_q;
    assign done       = done_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign flag_v     = flag_v_q;
    assign dbg_data   = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 4-bit ALU; honours ALU_SAT_EN.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [2:0] instr_rd, instr_rs, instr_rt;
    logic [3:0] alu_in1, alu_in2;
    logic [1:0] alu_opcode;
    logic [3:0] alu_out;
    logic       alu_error;
    logic       done;
    logic [3:0] result;
    logic       flag_z, flag_n, flag_v;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;
    logic       force_err;

    int n_checks = 0;
    int n_err    = 0;

    alu_exec_ctrl #(.DATA_W(4), .NREG(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_error(alu_error),
        .done(done), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: 00 ADD, 01 SUB, 10 NAND, 11 XOR; error = signed overflow
    always_comb begin
        logic [3:0] s;
        logic       ov;
        s  = '0;
        ov = 1'b0;
        case (alu_opcode)
            2'b00: begin s = alu_in1 + alu_in2; ov = (alu_in1[3] == alu_in2[3]) && (s[3] != alu_in1[3]); end
            2'b01: begin s = alu_in1 - alu_in2; ov = (alu_in1[3] != alu_in2[3]) && (s[3] != alu_in1[3]); end
            2'b10: s = ~(alu_in1 & alu_in2);
            default: s = alu_in1 ^ alu_in2;
        endcase
        alu_out   = s;
        alu_error = ov | force_err;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller ready; ends at the DONE-cycle negedge.
    task automatic run(input string tag, input logic [1:0] op, input logic [2:0] rd, rs, rt,
                       input logic [3:0] er, input logic ez, en, ev);
        chk({tag, ".ready"}, {7'd0, instr_ready}, 8'd1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        @(negedge clk);
        instr_valid = 1'b0;
        chk({tag, ".exec_ready"}, {7'd0, instr_ready}, 8'd0);
        chk({tag, ".exec_done"},  {7'd0, done}, 8'd0);
        @(negedge clk);
        chk({tag, ".done"},   {7'd0, done}, 8'd1);
        chk({tag, ".result"}, {4'd0, result}, {4'd0, er});
        chk({tag, ".flags"},  {5'd0, flag_z, flag_n, flag_v}, {5'd0, ez, en, ev});
    endtask

    task automatic go_idle(input string tag);
        @(negedge clk);
        chk({tag, ".done_fall"}, {7'd0, done}, 8'd0);
        chk({tag, ".idle_ready"}, {7'd0, instr_ready}, 8'd1);
    endtask

    task automatic rd_dbg(input string tag, input logic [2:0] a, input logic [3:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, {4'd0, dbg_data}, {4'd0, exp});
    endtask

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, NAND = 2'b10, XOR = 2'b11;

    logic [1:0] b_op  [4] = '{ADD, ADD, XOR, SUB};
    logic [2:0] b_rd  [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
    logic [2:0] b_rs  [4] = '{3'd3, 3'd1, 3'd2, 3'd1};
    logic [2:0] b_rt  [4] = '{3'd3, 3'd3, 3'd3, 3'd2};
    logic [3:0] b_in1 [4] = '{4'hF, 4'hE, 4'hD, 4'h2};
    logic [3:0] b_res [4] = '{4'hE, 4'hD, 4'h2, 4'h5};

`ifdef ALU_SAT_EN
    localparam logic [3:0] R7_EXP = 4'h8;
    localparam logic [2:0] R7_ZNV = 3'b011;
    localparam logic [3:0] R6_EXP = 4'h7;
    localparam logic [2:0] R6_ZNV = 3'b001;
`else
    localparam logic [3:0] R7_EXP = 4'h0;
    localparam logic [2:0] R7_ZNV = 3'b101;
    localparam logic [3:0] R6_EXP = 4'h8;
    localparam logic [2:0] R6_ZNV = 3'b011;
`endif

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0;
        instr_rd = '0; instr_rs = '0; instr_rt = '0;
        dbg_addr = '0; force_err = 1'b0;

        // 1. Reset state
        @(negedge clk);
        chk("rst.done",   {7'd0, done}, 8'd0);
        chk("rst.flags",  {5'd0, flag_z, flag_n, flag_v}, 8'd0);
        chk("rst.result", {4'd0, result}, 8'd0);
        chk("rst.alu",    {alu_in1, alu_in2}, 8'd0);
        chk("rst.ready",  {7'd0, instr_ready}, 8'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd_dbg($sformatf("rst.dbg%0d", i), 3'(i), 4'h0);

        // Reset asserted in EXEC: write lost, back to IDLE, no done
        @(negedge clk);
        instr_valid = 1'b1; instr_op = NAND; instr_rd = 3'd3; instr_rs = 3'd0; instr_rt = 3'd0;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid.in_exec", {7'd0, instr_ready}, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("mid.ready", {7'd0, instr_ready}, 8'd1);
        chk("mid.opc",   {6'd0, alu_opcode}, 8'd0);
        @(negedge clk);
        chk("mid.nodone", {7'd0, done}, 8'd0);
        rst_n = 1'b1;
        rd_dbg("mid.r3", 3'd3, 4'h0);
        @(negedge clk);
        chk("mid.nodone2", {7'd0, done}, 8'd0);

        // 2. Zero results
        run("add_r1", ADD, 3'd1, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        go_idle("add_r1");
        run("sub_r2", SUB, 3'd2, 3'd0, 3'd1, 4'h0, 1'b1, 1'b0, 1'b0);
        go_idle("sub_r2");

        // 3. Build -1 and -2 (back-to-back accept in DONE)
        run("nand_r3", NAND, 3'd3, 3'd0, 3'd0, 4'hF, 1'b0, 1'b1, 1'b0);
        run("add_r4",  ADD,  3'd4, 3'd3, 3'd3, 4'hE, 1'b0, 1'b1, 1'b0);

        // 4. -8, then overflow cases
        run("add_r5a", ADD, 3'd5, 3'd4, 3'd4, 4'hC, 1'b0, 1'b1, 1'b0);
        run("add_r5b", ADD, 3'd5, 3'd5, 3'd5, 4'h8, 1'b0, 1'b1, 1'b0);
        run("sub_r6",  SUB, 3'd6, 3'd5, 3'd3, 4'h9, 1'b0, 1'b1, 1'b0);
        run("ovf_r7",  ADD, 3'd7, 3'd5, 3'd5, R7_EXP, R7_ZNV[2], R7_ZNV[1], R7_ZNV[0]);
        run("ovf_r6",  SUB, 3'd6, 3'd0, 3'd5, R6_EXP, R6_ZNV[2], R6_ZNV[1], R6_ZNV[0]);
        rd_dbg("dbg.r7", 3'd7, R7_EXP);
        rd_dbg("dbg.r6", 3'd6, R6_EXP);

        // 5. Valid held high for four dependent instructions
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_op = b_op[i]; instr_rd = b_rd[i]; instr_rs = b_rs[i]; instr_rt = b_rt[i];
            chk($sformatf("b2b%0d.ready", i), {7'd0, instr_ready}, 8'd1);
            @(negedge clk);
            chk($sformatf("b2b%0d.busy", i), {6'd0, instr_ready, done}, 8'd0);
            chk($sformatf("b2b%0d.in1", i), {4'd0, alu_in1}, {4'd0, b_in1[i]});
            instr_op = NAND; instr_rd = 3'd7; instr_rs = 3'd0; instr_rt = 3'd0;
            @(negedge clk);
            chk($sformatf("b2b%0d.done", i), {7'd0, done}, 8'd1);
            chk($sformatf("b2b%0d.result", i), {4'd0, result}, {4'd0, b_res[i]});
        end
        instr_valid = 1'b0;
        go_idle("b2b");
        rd_dbg("b2b.r1", 3'd1, 4'h2);
        rd_dbg("b2b.r2", 3'd2, 4'h5);
        rd_dbg("b2b.r7", 3'd7, R7_EXP);

        // 6. XOR into R0 with forced alu_error
        force_err = 1'b1;
        run("xor_r0", XOR, 3'd0, 3'd3, 3'd4, 4'h1, 1'b0, 1'b0, 1'b0);
        go_idle("xor_r0");
        force_err = 1'b0;
        rd_dbg("xor.r0", 3'd0, 4'h0);

        // Idle with valid low: outputs hold whatever the inputs do
        instr_op = ADD; instr_rd = 3'd5; instr_rs = 3'd6; instr_rt = 3'd7;
        repeat (3) @(negedge clk);
        chk("hold.result", {4'd0, result}, 8'h01);
        chk("hold.ops",    {alu_in1, alu_in2}, 8'hFE);
        chk("hold.opc",    {6'd0, alu_opcode}, 8'd3);
        chk("hold.flags",  {4'd0, done, flag_z, flag_n, flag_v}, 8'd0);
        rd_dbg("hold.r5", 3'd5, 4'h8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "timeout");
    end

endmodule
